fp32_addmul_unit: RTL and testbench
===================================

Name: fp32_addmul_unit

Overview:
- Pipelined IEEE-754 single-precision arithmetic unit with two build-time variants: adder (OP=0) and multiplier (OP=1).
- Used as the MAC datapath of the FIR filter: two adders pre-add symmetric taps, and two multipliers apply the coefficients.
- New-data/ready handshake; fixed latency; fully pipelined, so it accepts one operation per clock.

Parameters:
- OP, 0, operation select: 0 = a+b, 1 = a*b.
- LATENCY, 4, clocks from the operation_nd sample edge to the rdy pulse; legal range 2..8.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  32  operand A, IEEE-754 binary32.
- b  input  32  operand B, IEEE-754 binary32.
- operation_nd  input  1  new data: a/b are captured on any rising edge where this is 1.
- operation_rfd  output  1  ready for data.
- result  output  32  registered result, binary32.
- rdy  output  1  one-cycle pulse marking a new valid result.

Behaviour:
- Reset is synchronous on clk, active-high (rst):
  - result=0x00000000, rdy=0, operation_rfd=0.
  - All in-flight operations are discarded; none produces a later rdy.
- operation_rfd=1 on every cycle after reset deasserts; the unit never back-pressures.
- Handshake:
  - Operands sampled at edge N with operation_nd=1 give result updated and rdy=1 at edge N+LATENCY.
  - rdy returns to 0 the next cycle unless another result completes.
  - result holds its value until the next completion.
- Back-to-back: operation_nd high on k consecutive cycles gives rdy high on k consecutive cycles, with results in issue order.
  - Pipeline valid bits shift with the data and have no interaction between slots.
- operation_nd=0 cycles create bubbles; a/b are don't-care on those cycles.
- Arithmetic (binary32, round-to-nearest-even):
  - Subnormal inputs are treated as same-signed zero (flush-to-zero).
  - Subnormal results are flushed to same-signed zero.
  - Overflow gives ±inf (0x7F800000 / 0xFF800000).
  - Any NaN input gives canonical NaN 0x7FC00000.
  - Add: inf+(-inf) gives 0x7FC00000. Exact-zero sum is +0, except (-0)+(-0)=-0.
  - Add datapath: exponent compare/swap, align with guard/round/sticky, add/subtract 24-bit mantissas, leading-zero normalize, round, renormalize on carry-out.
  - Mul: sign = sa XOR sb; 24x24 mantissa product; exponent = ea+eb-127; normalize by 1 bit; round; 0*inf gives 0x7FC00000; zero*finite gives signed zero.
- Reset asserted mid-operation: the rdy pulse for the pending result is suppressed. The first result after reset comes only from operation_nd asserted after reset is released.
- No status flags; exceptions are encoded in result only.

Test Plan:
- Reset, then idle → result=0x00000000, rdy=0 throughout; operation_rfd=1 from the first cycle after reset.
- OP=0, a=0x3F800000, b=0x40000000, single nd pulse → rdy exactly 4 cycles later, result=0x40400000 (3.0). Then a=0x3CA161E5, b=0xBCA161E5 → result=0x00000000.
- OP=1, a=0x3FC00000, b=0x40000000 → result=0x40400000. Then a=0x3F1D0E56, b=0x00000000 → 0x00000000. Then a=0x7F7FFFFF, b=0x40000000 → 0x7F800000.
- Specials:
  - OP=0: a=0x7F800000, b=0xFF800000 → 0x7FC00000.
  - OP=1: a=0x00000000, b=0x7F800000 → 0x7FC00000.
  - Subnormal a=0x00000001 plus b=0x3F800000 → 0x3F800000.
- Back-to-back (OP=0): nd high 3 cycles with (1+1), (2+2), (1+(-1)) → rdy high 3 consecutive cycles with 0x40000000, 0x40800000, 0x00000000.
- Reset mid-flight: issue an op, assert rst 2 cycles later for 1 cycle → no rdy ever appears for that op; result=0. Then 1.0*1.0 (OP=1) → 0x3F800000 after LATENCY.

Source files
------------

// File: rtl/fp32_addmul_unit.sv
// Pipelined binary32 adder (OP=0) or multiplier (OP=1), round-to-nearest-even, flush-to-zero.
// Operands are registered on operation_nd; result/rdy appear LATENCY clocks after that edge.
module fp32_addmul_unit #(
    parameter int OP      = 0,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        operation_nd,
    output logic        operation_rfd,
    output logic [31:0] result,
    output logic        rdy
);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // valid/ready: a/b are taken on every rising edge with operation_nd=1 (rfd is
    // always 1 out of reset); rdy pulses for one cycle per completed operation.

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 27; i++)
            if (v[i]) c = 5'(26 - i);
        return c;
    endfunction

    // n = {hidden+23 mantissa bits, guard, round, sticky}; e is the biased exponent
    function automatic logic [31:0] round_pack(input logic s, input logic signed [11:0] e,
                                               input logic [26:0] n);
        logic [24:0]        mr;
        logic signed [11:0] ef;
        logic               rup;
        rup = n[2] & (n[1] | n[0] | n[3]);
        mr  = {1'b0, n[26:3]} + {24'd0, rup};
        ef  = e;
        if (mr[24]) begin
            ef = e + 12'sd1;
            mr = mr >> 1;
        end
        if (ef <= 12'sd0)       return {s, 31'd0};
        else if (ef >= 12'sd255) return {s, 8'hFF, 23'd0};
        else                    return {s, ef[7:0], mr[22:0]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic               xz, yz, xi, yi, xn, yn;
        logic [31:0]        big, sml;
        logic [7:0]         d;
        logic [49:0]        sh;
        logic [26:0]        al, mbx, n;
        logic [27:0]        s;
        logic [4:0]         lz;
        logic signed [11:0] e;
        xz = (x[30:23] == 8'd0);
        yz = (y[30:23] == 8'd0);
        xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
        xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
        if (xn || yn) return QNAN;
        if (xi && yi && (x[31] != y[31])) return QNAN;
        if (xi) return x;
        if (yi) return y;
        if (xz && yz) return {x[31] & y[31], 31'd0};
        if (xz) return y;
        if (yz) return x;
        if (x[30:0] >= y[30:0]) begin
            big = x;
            sml = y;
        end else begin
            big = y;
            sml = x;
        end
        d   = big[30:23] - sml[30:23];
        sh  = {1'b1, sml[22:0], 26'd0} >> d;
        al  = {sh[49:24], |sh[23:0]};
        mbx = {1'b1, big[22:0], 3'd0};
        if (big[31] == sml[31]) s = {1'b0, mbx} + {1'b0, al};
        else                    s = {1'b0, mbx} - {1'b0, al};
        if (s == 28'd0) return 32'd0;
        if (s[27]) begin
            n = {s[27:2], s[1] | s[0]};
            e = $signed({4'd0, big[30:23]}) + 12'sd1;
        end else begin
            lz = lzc27(s[26:0]);
            n  = s[26:0] << lz;
            e  = $signed({4'd0, big[30:23]}) - $signed({7'd0, lz});
        end
        return round_pack(big[31], e, n);
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
        logic               xz, yz, xi, yi, xn, yn, s;
        logic [47:0]        p;
        logic [26:0]        n;
        logic signed [11:0] e;
        xz = (x[30:23] == 8'd0);
        yz = (y[30:23] == 8'd0);
        xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
        xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
        s  = x[31] ^ y[31];
        if (xn || yn) return QNAN;
        if ((xi && yz) || (yi && xz)) return QNAN;
        if (xi || yi) return {s, 8'hFF, 23'd0};
        if (xz || yz) return {s, 31'd0};
        p = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
        e = $signed({4'd0, x[30:23]}) + $signed({4'd0, y[30:23]}) - 12'sd127;
        if (p[47]) begin
            n = {p[47:22], |p[21:0]};
            e = e + 12'sd1;
        end else begin
            n = {p[46:21], |p[20:0]};
        end
        return round_pack(s, e, n);
    endfunction

    logic [31:0]          a_q, b_q, calc;
    logic                 nd_q;
    logic [31:0]          pipe_d [LATENCY-1];
    logic [LATENCY-2:0]   pipe_v;

    generate
        if (OP == 1) begin : g_mul
            always_comb calc = fp_mul(a_q, b_q);
        end else begin : g_add
            always_comb calc = fp_add(a_q, b_q);
        end
    endgenerate

    // Data path carries no reset; only the valid bits and visible outputs are cleared.
    always_ff @(posedge clk) begin
        if (operation_nd) begin
            a_q <= a;
            b_q <= b;
        end
        pipe_d[0] <= calc;
        for (int i = 1; i < LATENCY - 1; i++)
            pipe_d[i] <= pipe_d[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nd_q          <= 1'b0;
            pipe_v        <= '0;
            rdy           <= 1'b0;
            result        <= 32'd0;
            operation_rfd <= 1'b0;
        end else begin
            nd_q      <= operation_nd;
            pipe_v[0] <= nd_q;
            for (int i = 1; i < LATENCY - 1; i++)
                pipe_v[i] <= pipe_v[i-1];
            rdy <= pipe_v[LATENCY-2];
            if (pipe_v[LATENCY-2]) result <= pipe_d[LATENCY-2];
            operation_rfd <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fp32_addmul_unit.sv
// Directed bench for the adder and multiplier builds of fp32_addmul_unit.
module tb_fp32_addmul_unit;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] add_a, add_b, add_res, mul_a, mul_b, mul_res;
  logic        add_nd, add_rfd, add_rdy, mul_nd, mul_rfd, mul_rdy;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  logic [31:0] exp_add_q[$];
  int          due_add_q[$];
  string       name_add_q[$];
  logic [31:0] exp_mul_q[$];
  int          due_mul_q[$];
  string       name_mul_q[$];

  typedef struct {
    bit          op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[$];

  fp32_addmul_unit #(.OP(0), .LATENCY(LAT)) u_add (
    .clk(clk), .rst(rst), .a(add_a), .b(add_b), .operation_nd(add_nd),
    .operation_rfd(add_rfd), .result(add_res), .rdy(add_rdy)
  );

  fp32_addmul_unit #(.OP(1), .LATENCY(LAT)) u_mul (
    .clk(clk), .rst(rst), .a(mul_a), .b(mul_b), .operation_nd(mul_nd),
    .operation_rfd(mul_rfd), .result(mul_res), .rdy(mul_rdy)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // scoreboard: results in issue order, each on its due cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (add_rdy) begin
        if (exp_add_q.size() == 0) flag("add_spurious_rdy: got rdy=1 want rdy=0");
        else begin
          check(name_add_q.pop_front(), add_res, exp_add_q.pop_front());
          check("add_latency", cyc, due_add_q.pop_front());
        end
      end else if (due_add_q.size() > 0 && due_add_q[0] <= cyc) begin
        flag({"add_missing_rdy ", name_add_q[0], ": got rdy=0 want rdy=1"});
        void'(exp_add_q.pop_front());
        void'(due_add_q.pop_front());
        void'(name_add_q.pop_front());
      end
      if (mul_rdy) begin
        if (exp_mul_q.size() == 0) flag("mul_spurious_rdy: got rdy=1 want rdy=0");
        else begin
          check(name_mul_q.pop_front(), mul_res, exp_mul_q.pop_front());
          check("mul_latency", cyc, due_mul_q.pop_front());
        end
      end else if (due_mul_q.size() > 0 && due_mul_q[0] <= cyc) begin
        flag({"mul_missing_rdy ", name_mul_q[0], ": got rdy=0 want rdy=1"});
        void'(exp_mul_q.pop_front());
        void'(due_mul_q.pop_front());
        void'(name_mul_q.pop_front());
      end
    end
  end

  // driver: one cycle with operation_nd high on the selected unit
  task automatic issue(input bit op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string name, input bit track);
    if (op) begin
      mul_a = a; mul_b = b; mul_nd = 1'b1; add_nd = 1'b0;
      if (track) begin
        exp_mul_q.push_back(exp); due_mul_q.push_back(cyc + 1 + LAT); name_mul_q.push_back(name);
      end
    end else begin
      add_a = a; add_b = b; add_nd = 1'b1; mul_nd = 1'b0;
      if (track) begin
        exp_add_q.push_back(exp); due_add_q.push_back(cyc + 1 + LAT); name_add_q.push_back(name);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    add_nd = 1'b0;
    mul_nd = 1'b0;
    add_a = $urandom();
    add_b = $urandom();
    mul_a = $urandom();
    mul_b = $urandom();
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vecs.push_back('{0, 32'h3F800000, 32'h40000000, 32'h40400000, "add_1p2"});
    vecs.push_back('{0, 32'h3CA161E5, 32'hBCA161E5, 32'h00000000, "add_cancel"});
    vecs.push_back('{0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, "add_inf_minus_inf"});
    vecs.push_back('{0, 32'h00000001, 32'h3F800000, 32'h3F800000, "add_subnormal_ftz"});
    vecs.push_back('{0, 32'h3F800000, 32'h33800000, 32'h3F800000, "add_tie_even"});
    vecs.push_back('{0, 32'h3F800000, 32'h33800001, 32'h3F800001, "add_round_up"});
    vecs.push_back('{0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, "add_nan_in"});
    vecs.push_back('{0, 32'h80000000, 32'h80000000, 32'h80000000, "add_neg0_neg0"});
    vecs.push_back('{0, 32'h80000000, 32'h00000000, 32'h00000000, "add_neg0_pos0"});
    vecs.push_back('{0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, "add_overflow"});
    vecs.push_back('{0, 32'h40400000, 32'hC0000000, 32'h3F800000, "add_3_minus_2"});
    vecs.push_back('{1, 32'h3FC00000, 32'h40000000, 32'h40400000, "mul_1p5x2"});
    vecs.push_back('{1, 32'h3F1D0E56, 32'h00000000, 32'h00000000, "mul_by_zero"});
    vecs.push_back('{1, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, "mul_overflow"});
    vecs.push_back('{1, 32'h00000000, 32'h7F800000, 32'h7FC00000, "mul_zero_inf"});
    vecs.push_back('{1, 32'hC0000000, 32'h40400000, 32'hC0C00000, "mul_neg"});
    vecs.push_back('{1, 32'h3F800001, 32'h3F800001, 32'h3F800002, "mul_lsb"});
    vecs.push_back('{1, 32'h00800000, 32'h00800000, 32'h00000000, "mul_underflow"});
    vecs.push_back('{1, 32'h80000000, 32'h3F800000, 32'h80000000, "mul_neg_zero"});
    vecs.push_back('{1, 32'hFF800000, 32'h40000000, 32'hFF800000, "mul_neg_inf"});

    rst = 1'b1;
    idle(3);
    check("rst_add_rfd", {31'd0, add_rfd}, 32'd0);
    check("rst_mul_rfd", {31'd0, mul_rfd}, 32'd0);
    check("rst_add_result", add_res, 32'd0);
    check("rst_mul_rdy", {31'd0, mul_rdy}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_add_rfd", {31'd0, add_rfd}, 32'd1);
    check("post_rst_mul_rfd", {31'd0, mul_rfd}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("idle_add_result", add_res, 32'd0);
      check("idle_mul_result", mul_res, 32'd0);
      check("idle_add_rdy", {31'd0, add_rdy}, 32'd0);
      check("idle_mul_rdy", {31'd0, mul_rdy}, 32'd0);
      idle(1);
    end

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name, 1'b1);
      idle(LAT + 2);
      check(vecs[i].op ? "mul_hold" : "add_hold", vecs[i].op ? mul_res : add_res, vecs[i].exp);
    end

    // back-to-back adds
    issue(0, 32'h3F800000, 32'h3F800000, 32'h40000000, "b2b_1p1", 1'b1);
    issue(0, 32'h40000000, 32'h40000000, 32'h40800000, "b2b_2p2", 1'b1);
    issue(0, 32'h3F800000, 32'hBF800000, 32'h00000000, "b2b_1m1", 1'b1);
    idle(LAT + 3);

    // reset while a multiply is in flight: it must never complete
    issue(1, 32'h40000000, 32'h40400000, 32'h0, "killed", 1'b0);
    idle(1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(LAT + 3);
    check("post_kill_mul_result", mul_res, 32'd0);
    check("post_kill_add_result", add_res, 32'd0);
    issue(1, 32'h3F800000, 32'h3F800000, 32'h3F800000, "mul_after_rst", 1'b1);
    idle(LAT + 3);

    check("add_queue_drained", exp_add_q.size(), 32'd0);
    check("mul_queue_drained", exp_mul_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
